datamem_sync: RTL and testbench
===============================

# datamem_sync

Parametrised, clocked successor to the SEQ memory-stage data memory. It is byte-addressable and little-endian, performs Y86-64 8-byte accesses at any byte address, and applies a req/ready handshake with a programmable number of wait states. Bounds errors are reported with the completion, never mid-access. It sits in the Memory stage and serves the staged and pipelined cores, which stall on `ready` and sample `rdata`/`dmem_error` on `done`.

## Interface
- `DEPTH_BYTES`, default 4096: memory size in bytes; must be ≥ `WORD_BYTES`.
- `WORD_BYTES`, default 8: bytes per access; data width is 8·`WORD_BYTES`.
- `ADDR_W`, default 64: address width; the address is treated as signed.
- `WAIT_CYCLES`, default 1: wait states per access; 0 is legal.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request; sampled only when `ready`=1.
- `we`  in  1  1 = write, 0 = read; latched with `req`.
- `addr`  in  `ADDR_W`  signed byte address of the lowest byte.
- `wdata`  in  8·`WORD_BYTES`  write data; byte 0 = `wdata[7:0]`.
- `ready`  out  1  block is idle and will accept `req`.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  8·`WORD_BYTES`  read result.
- `dmem_error`  out  1  error status of the access completing this cycle; valid with `done`.

## Operation
- Storage: `DEPTH_BYTES` × 8-bit array. Reset does not clear it; contents are X until written.
- States:
  - IDLE: `ready`=1.
  - BUSY: wait-state counter running.
  - RESP: `done`=1.
- IDLE→BUSY on an edge with `req`=1. At that edge, latch `addr`, `we` and `wdata`, compute `err`, and load the counter with `WAIT_CYCLES`.
- `err` = (`addr` MSB = 1) or (`addr` > `DEPTH_BYTES` − `WORD_BYTES`), using an unsigned compare on non-negative values.
- BUSY on each edge:
  - Counter ≠ 0: decrement.
  - Counter = 0: perform the access and go to RESP.
- Access when `err`=0:
  - Write: byte `addr`+i ← `wdata[8i+7:8i]` for i = 0..`WORD_BYTES`−1. `rdata` is unchanged.
  - Read: `rdata[8i+7:8i]` ← byte `addr`+i.
- Access when `err`=1: no array write; `rdata` ← 0; `dmem_error` ← 1.
- RESP→IDLE unconditionally on the next edge. `req` is ignored in BUSY and RESP.
- `dmem_error` is registered with the access. It holds until the next completion, then is cleared or set by that access.
- `rdata` holds until the next completing read or error.
- Unaligned addresses are legal. Overlapping accesses see byte-exact results.

## Timing
- Reset (async assert, any state):
  - state = IDLE, `ready`=1, `done`=0, `rdata`=0, `dmem_error`=0, counter=0.
  - An in-flight access is discarded with no partial write, because the array is written only on the BUSY→RESP edge.
  - Deassertion is synchronous in effect: the first accepting edge is the first rising edge with `rst_n`=1.
- Latency:
  - Request accepted at edge E0.
  - `done`=1 during the cycle after edge E0+`WAIT_CYCLES`+1.
  - `ready` returns 1 one cycle later.
  - Throughput is one access per `WAIT_CYCLES`+3 cycles.
- Errored accesses take the same latency as good ones.
- `ready` is 0 from the cycle after E0 until the cycle after RESP.
- A write followed by a read of the same bytes returns the new data; there is no forwarding hazard, because accesses are serialised.

## Test plan
- Round trip (W=1): write `addr`=0x10, `wdata`=0x1122334455667788, then read 0x10. Required: `done` in cycle E0+2 of each access, `rdata`=0x1122334455667788, `dmem_error`=0.
- Unaligned overlap: write 0x1122334455667788 at 0, then write 0x00000000AABBCCDD at 4, then read 0. Required: `rdata`=0xAABBCCDD55667788.
- Bounds (4096/8):
  - Read 4088 gives `dmem_error`=0.
  - Write 4089 gives `dmem_error`=1, `rdata`=0, and a subsequent read of 4088 shows unchanged memory.
  - `addr`=−8 gives `dmem_error`=1.
- Busy protocol: hold `req`=1 for 6 cycles with W=2, changing `addr` each cycle. Required: exactly two accesses, each using the address present when `ready`=1, and `done` pulses one cycle wide.
- Reset mid-access: write 0xDEAD at 0x20 with W=3, then pull `rst_n` low in BUSY. Required: all outputs go to reset values immediately, and a later read of 0x20 returns the prior value, not 0xDEAD.
- W=0: a read is accepted at E0 and `done`=1 in the cycle after E0+1.

Source files
------------

// File: rtl/datamem_sync.sv
// Purpose: byte-addressable little-endian data memory, WORD_BYTES-wide access at any byte address.
// Latency: done pulses in the cycle after edge E0+WAIT_CYCLES+1 (E0 = accepting edge); one access per WAIT_CYCLES+3 cycles.
// Backpressure: ready=1 only while idle; req is ignored while an access is in flight.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req, we          access request (sampled when ready=1), 1 = write
//   addr             signed byte address of the lowest byte
//   wdata            write data, byte 0 in wdata[7:0]
//   ready            idle, will accept req
//   done             one-cycle completion pulse
//   rdata            read result, held until the next completing read or error
//   dmem_error       bounds error of the access completing, valid with done
module datamem_sync #(
  parameter int DEPTH_BYTES = 4096,
  parameter int WORD_BYTES  = 8,
  parameter int ADDR_W      = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [8*WORD_BYTES-1:0] wdata,
  output logic                    ready,
  output logic                    done,
  output logic [8*WORD_BYTES-1:0] rdata,
  output logic                    dmem_error
);

  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int IDX_W  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  // Highest legal start address: the whole word must fit in the array.
  localparam logic [ADDR_W-1:0] LAST_OK  = ADDR_W'(DEPTH_BYTES - WORD_BYTES);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic              err_q;
  logic [IDX_W-1:0]  base_q;
  logic [DATA_W-1:0] wdata_q;

  // Storage is deliberately not reset; contents are undefined until written.
  logic [7:0] mem [DEPTH_BYTES];

  logic              addr_err;
  logic              do_access;
  logic [DATA_W-1:0] read_word;

  // Negative addresses fail on the sign bit; non-negative ones on an
  // unsigned compare against the last legal start address.
  assign addr_err  = addr[ADDR_W-1] | (addr > LAST_OK);
  assign do_access = (state == BUSY) && (cnt == '0);

  // Only the low index bits are kept: a non-errored access always lies
  // entirely inside the array, so base_q + i never leaves it.
  always_comb begin
    read_word = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      read_word[8*i +: 8] = mem[base_q + IDX_W'(i)];
    end
  end

  // The array is touched only on the BUSY->RESP edge, so a reset during
  // the wait states can never leave a partially written word.
  always_ff @(posedge clk) begin
    if (do_access && we_q && !err_q) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        mem[base_q + IDX_W'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      cnt        <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      rdata      <= '0;
      dmem_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state   <= BUSY;
            ready   <= 1'b0;
            we_q    <= we;
            err_q   <= addr_err;
            base_q  <= addr[IDX_W-1:0];
            wdata_q <= wdata;
            cnt     <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state      <= RESP;
            done       <= 1'b1;
            dmem_error <= err_q;
            // Writes leave rdata alone; errors force it to zero.
            if (err_q) begin
              rdata <= '0;
            end else if (!we_q) begin
              rdata <= read_word;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datamem_sync.sv
// Purpose: scoreboard bench for datamem_sync across wait-state settings 1, 2, 3 and 0.
// Latency: expected completion edge derived from the accept edge plus WAIT_CYCLES+1.
// Backpressure: stimulus only issues while the block is idle, except the held-req check.
module tb_datamem_sync;

  localparam int NI    = 4;
  localparam int DEPTH = 4096;
  localparam int WB    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [NI];
  logic        req   [NI];
  logic        we    [NI];
  logic [63:0] addr  [NI];
  logic [63:0] wdata [NI];
  logic        ready [NI];
  logic        done  [NI];
  logic [63:0] rdata [NI];
  logic        err   [NI];

  // Instance g runs with WAIT_CYCLES = (g+1)%4, i.e. 1, 2, 3, 0.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    datamem_sync #(
      .DEPTH_BYTES(DEPTH),
      .WORD_BYTES (WB),
      .ADDR_W     (64),
      .WAIT_CYCLES((g + 1) % 4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req       (req[g]),
      .we        (we[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .ready     (ready[g]),
      .done      (done[g]),
      .rdata     (rdata[g]),
      .dmem_error(err[g])
    );
  end

  int n_vec  = 0;
  int n_bad  = 0;
  int edge_n = 0;
  int cur    = 0;
  int ws     = 1;

  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    logic [63:0] data;
    logic [63:0] mask;
    logic        e;
    int          at;
  } exp_t;

  exp_t sb[$];

  // Reference model: a plain byte array plus a "has been written" flag per byte.
  logic [7:0]  mm [DEPTH];
  bit          mk [DEPTH];
  logic [63:0] last_d;
  logic [63:0] last_m;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (inst %0d, edge %0d): got %h want %h", nm, cur, edge_n, act, exp);
    end
  endtask

  task automatic model(input bit w, input logic [63:0] a, input logic [63:0] d);
    exp_t   e;
    longint sa;
    sa = longint'(a);
    if (sa < 0 || sa > DEPTH - WB) begin
      last_d = '0;
      last_m = '1;
      e.e    = 1'b1;
    end else if (w) begin
      for (int i = 0; i < WB; i++) begin
        mm[int'(sa) + i] = d[8*i +: 8];
        mk[int'(sa) + i] = 1'b1;
      end
      e.e = 1'b0;
    end else begin
      for (int i = 0; i < WB; i++) begin
        last_d[8*i +: 8] = mm[int'(sa) + i];
        last_m[8*i +: 8] = mk[int'(sa) + i] ? 8'hFF : 8'h00;
      end
      e.e = 1'b0;
    end
    e.data = last_d;
    e.mask = last_m;
    // Driven at negedge k, accepted at edge k+1, done seen after edge k+1+ws+1.
    e.at   = edge_n + ws + 2;
    sb.push_back(e);
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      mk[i] = 1'b0;
      mm[i] = 8'h00;
    end
    last_d = '0;
    last_m = '1;
  endtask

  // One complete transaction, called at a negedge while the DUT is idle;
  // returns at the negedge where it is idle again.
  task automatic access(input bit w, input logic [63:0] a, input logic [63:0] d);
    check("ready_idle", ready[cur], 1);
    req[cur]   = 1'b1;
    we[cur]    = w;
    addr[cur]  = a;
    wdata[cur] = d;
    model(w, a, d);
    @(negedge clk);
    req[cur] = 1'b0;
    repeat (ws + 1) @(negedge clk);
    check("ready_busy", ready[cur], 0);
    @(negedge clk);
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (done[g] === 1'b1) begin
        if (g != cur || sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL spurious_done (inst %0d, edge %0d): got done=1 want none", g, edge_n);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_edge", 64'(edge_n), 64'(e.at));
          check("rdata", rdata[g] & e.mask, e.data & e.mask);
          check("dmem_error", err[g], e.e);
        end
      end
    end
  end

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    int          r;
    for (int g = 0; g < NI; g++) begin
      rst_n[g] = 1'b0;
      req[g]   = 1'b0;
      we[g]    = 1'b0;
      addr[g]  = '0;
      wdata[g] = '0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      cur = g;
      check("rst_ready", ready[g], 1);
      check("rst_done",  done[g],  0);
      check("rst_rdata", rdata[g], 0);
      check("rst_err",   err[g],   0);
      rst_n[g] = 1'b1;
    end
    @(negedge clk);

    for (int g = 0; g < NI; g++) begin
      cur = g;
      ws  = (g + 1) % 4;
      clear_model();

      // Round trip.
      access(1'b1, 64'h10, 64'h1122334455667788);
      access(1'b0, 64'h10, 64'h0);

      // Unaligned overlap.
      access(1'b1, 64'h0, 64'h1122334455667788);
      access(1'b1, 64'h4, 64'h00000000AABBCCDD);
      access(1'b0, 64'h0, 64'h0);

      // Bounds.
      access(1'b1, 64'd4088, {$urandom, $urandom});
      access(1'b0, 64'd4088, 64'h0);
      access(1'b1, 64'd4089, {$urandom, $urandom});
      access(1'b0, 64'd4088, 64'h0);
      access(1'b0, -64'sd8, 64'h0);
      access(1'b0, 64'd4096, 64'h0);
      access(1'b0, 64'h8000000000000000, 64'h0);

      // Held req with a new address every cycle: only the addresses present
      // while idle are used, one access per ws+3 cycles.
      for (int j = 0; j < 6; j++) begin
        access(1'b1, 64'h100 + 64'(8 * j), {$urandom, $urandom});
      end
      check("ready_idle", ready[cur], 1);
      for (int j = 0; j < 6; j++) begin
        req[cur]  = 1'b1;
        we[cur]   = 1'b0;
        addr[cur] = 64'h100 + 64'(8 * j);
        if (j == 0 || j == ws + 3) model(1'b0, addr[cur], 64'h0);
        @(negedge clk);
      end
      req[cur] = 1'b0;
      repeat (ws + 3) @(negedge clk);

      // Reset in the middle of a write: nothing is committed.
      access(1'b1, 64'h20, 64'h0123456789ABCDEF);
      access(1'b0, 64'h20, 64'h0);
      check("ready_idle", ready[cur], 1);
      req[cur]   = 1'b1;
      we[cur]    = 1'b1;
      addr[cur]  = 64'h20;
      wdata[cur] = 64'hDEAD;
      @(negedge clk);
      req[cur]   = 1'b0;
      rst_n[cur] = 1'b0;
      #1;
      check("midrst_ready", ready[cur], 1);
      check("midrst_done",  done[cur],  0);
      check("midrst_rdata", rdata[cur], 0);
      check("midrst_err",   err[cur],   0);
      last_d = '0;
      last_m = '1;
      @(negedge clk);
      rst_n[cur] = 1'b1;
      @(negedge clk);
      access(1'b0, 64'h20, 64'h0);

      // Random traffic, biased towards a small window so accesses overlap.
      for (int n = 0; n < 40; n++) begin
        r = $urandom_range(0, 9);
        if (r < 6)       a = 64'($urandom_range(0, 255));
        else if (r < 8)  a = 64'($urandom_range(0, DEPTH - WB));
        else if (r == 8) a = 64'($urandom_range(DEPTH - 16, DEPTH + 8));
        else             a = -64'($urandom_range(1, 16));
        d = {$urandom, $urandom};
        access(1'($urandom_range(0, 1)), a, d);
      end

      repeat (4) @(negedge clk);
      check("sb_drain", 64'(sb.size()), 64'd0);
      sb.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
